// File: rtl/conv_result_writer_if.sv
// Result-input and byte-write bus of the convolution result writer.
// The producer/memory side uses master; the writer itself uses slave.
interface conv_result_writer_if #(
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic [ACC_W-1:0]  in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/conv_result_writer.sv
// Writes per-channel accumulator results as clamped bytes into a BMP pixel array,
// appending zero bytes so every row stride is a multiple of 4.
module conv_result_writer #(
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 32,
    parameter int SHIFT  = 0
) (
    input  logic              Clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       img_cols,
    input  logic [15:0]       img_rows,
    conv_result_writer_if.slave bus,
    output logic              busy,
    output logic              done,
    output logic [15:0]       sat_count
);
    typedef enum logic [1:0] {IDLE, PIX, PAD, DONE} stateType;

    stateType          state, stateNext;
    logic [ADDR_W-1:0] rowBase;
    logic [17:0]       byteIdx, rowBytes, stride;
    logic [1:0]        padLen, padIdx;
    logic [15:0]       rowIdx, rowCount;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [7:0]        memWdata;
    logic [15:0]       satCount;

    logic              handshake, padStep, endRow, lastRow, startAccept;
    logic [17:0]       newRowBytes;
    logic [1:0]        newPad;

    // Geometry derived from the live inputs; only captured on an accepted start.
    assign newRowBytes = 18'(img_cols) * 18'd3;
    assign newPad      = 2'(2'd0 - newRowBytes[1:0]);

    logic signed [ACC_W-1:0] shifted;
    logic                    isNeg, isOver;
    logic [7:0]              clampByte;

    assign shifted   = $signed(bus.in_data) >>> SHIFT;
    assign isNeg     = shifted[ACC_W-1];
    assign isOver    = !isNeg && (|shifted[ACC_W-2:8]);
    assign clampByte = isNeg ? 8'h00 : (isOver ? 8'hFF : shifted[7:0]);

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            // NOTE: non-blocking assignment so every register samples pre-edge values.
            state <= stateNext;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
        stateNext   = state;
        handshake   = 1'b0;
        padStep     = 1'b0;
        endRow      = 1'b0;
        startAccept = 1'b0;
        lastRow     = (rowIdx == rowCount - 16'd1);
        case (state)
            IDLE: begin
                if (start) begin
                    startAccept = 1'b1;
                    stateNext   = (img_cols == 16'd0 || img_rows == 16'd0) ? DONE : PIX;
                end
            end
            PIX: begin
                if (bus.in_valid) begin
                    handshake = 1'b1;
                    if (byteIdx == rowBytes - 18'd1) begin
                        if (padLen != 2'd0) begin
                            stateNext = PAD;
                        end else begin
                            endRow    = 1'b1;
                            stateNext = lastRow ? DONE : PIX;
                        end
                    end
                end
            end
            PAD: begin
                padStep = 1'b1;
                if (padIdx == padLen - 2'd1) begin
                    endRow    = 1'b1;
                    stateNext = lastRow ? DONE : PIX;
                end
            end
            DONE: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            rowBase  <= '0;
            byteIdx  <= '0;
            rowBytes <= '0;
            stride   <= '0;
            padLen   <= '0;
            padIdx   <= '0;
            rowIdx   <= '0;
            rowCount <= '0;
            memWe    <= 1'b0;
            memAddr  <= '0;
            memWdata <= '0;
            satCount <= '0;
        end else begin
            memWe <= 1'b0;
            if (startAccept) begin
                rowBase  <= base_addr;
                rowBytes <= newRowBytes;
                padLen   <= newPad;
                stride   <= newRowBytes + 18'(newPad);
                rowCount <= img_rows;
                rowIdx   <= '0;
                byteIdx  <= '0;
                padIdx   <= '0;
                satCount <= '0;
            end
            if (handshake) begin
                memWe    <= 1'b1;
                memAddr  <= rowBase + ADDR_W'(byteIdx);
                memWdata <= clampByte;
                byteIdx  <= byteIdx + 18'd1;
                if ((isNeg || isOver) && satCount != 16'hFFFF) begin
                    satCount <= satCount + 16'd1;
                end
            end
            if (padStep) begin
                memWe    <= 1'b1;
                memAddr  <= rowBase + ADDR_W'(byteIdx);
                memWdata <= 8'h00;
                byteIdx  <= byteIdx + 18'd1;
                padIdx   <= padIdx + 2'd1;
            end
            // Placed last so the row restart overrides the per-byte increments above.
            if (endRow) begin
                rowIdx  <= rowIdx + 16'd1;
                byteIdx <= '0;
                padIdx  <= '0;
                rowBase <= rowBase + ADDR_W'(stride);
            end
        end
    end

    assign bus.in_ready  = (state == PIX);
    assign bus.mem_we    = memWe;
    assign bus.mem_addr  = memAddr;
    assign bus.mem_wdata = memWdata;
    assign busy          = (state == PIX) || (state == PAD);
    assign done          = (state == DONE);
    assign sat_count     = satCount;
endmodule

// File: tb/tb_conv_result_writer.sv
// Directed bench for conv_result_writer: one unscaled instance and one with SHIFT=4,
// each with a write/done logger sampled on the falling edge.
module tb_conv_result_writer;
    logic        Clk = 1'b0;
    logic        reset_n;
    logic        start0, start4;
    logic [31:0] base_addr;
    logic [15:0] img_cols, img_rows;
    logic        busy0, done0, busy4, done4;
    logic [15:0] sat0, sat4;

    int errors = 0;
    int checks = 0;

    conv_result_writer_if #(.ACC_W(32), .ADDR_W(32)) b0 ();
    conv_result_writer_if #(.ACC_W(32), .ADDR_W(32)) b4 ();

    conv_result_writer #(.ACC_W(32), .ADDR_W(32), .SHIFT(0)) dut0 (
        .Clk(Clk), .reset_n(reset_n), .start(start0), .base_addr(base_addr),
        .img_cols(img_cols), .img_rows(img_rows), .bus(b0),
        .busy(busy0), .done(done0), .sat_count(sat0)
    );

    conv_result_writer #(.ACC_W(32), .ADDR_W(32), .SHIFT(4)) dut4 (
        .Clk(Clk), .reset_n(reset_n), .start(start4), .base_addr(base_addr),
        .img_cols(img_cols), .img_rows(img_rows), .bus(b4),
        .busy(busy4), .done(done4), .sat_count(sat4)
    );

    always #5 Clk = ~Clk;

    logic [31:0] wa0[$], wa4[$];
    logic [7:0]  wd0[$], wd4[$];
    int doneCnt0 = 0, doneWe0 = 0, padCyc0 = 0, doneCnt4 = 0;

    always @(negedge Clk) begin
        if (b0.mem_we) begin
            wa0.push_back(b0.mem_addr);
            wd0.push_back(b0.mem_wdata);
        end
        if (b4.mem_we) begin
            wa4.push_back(b4.mem_addr);
            wd4.push_back(b4.mem_wdata);
        end
        if (done0) doneCnt0 <= doneCnt0 + 1;
        if (done0 && b0.mem_we) doneWe0 <= doneWe0 + 1;
        if (busy0 && !b0.in_ready) padCyc0 <= padCyc0 + 1;
        if (done4) doneCnt4 <= doneCnt4 + 1;
    end

    task automatic start_frame(input bit which, input logic [31:0] base,
                               input logic [15:0] cols, input logic [15:0] rows);
        base_addr = base;
        img_cols  = cols;
        img_rows  = rows;
        if (which) start4 = 1'b1; else start0 = 1'b1;
        @(posedge Clk); #1;
        start0 = 1'b0;
        start4 = 1'b0;
    endtask

    // Presents one result and returns #1 after the edge that accepted it.
    task automatic send(input bit which, input logic [31:0] val);
        int n = 0;
        if (which) begin
            b4.in_valid = 1'b1;
            b4.in_data  = val;
            while (!b4.in_ready && n < 100) begin @(posedge Clk); #1; n++; end
        end else begin
            b0.in_valid = 1'b1;
            b0.in_data  = val;
            while (!b0.in_ready && n < 100) begin @(posedge Clk); #1; n++; end
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready stayed %0b, required 1", 1'b0);
        end
        @(posedge Clk); #1;
    endtask

    task automatic wait_done(input bit which, input int base);
        int n = 0;
        while (((which ? doneCnt4 : doneCnt0) == base) && n < 300) begin
            @(negedge Clk); #1; n++;
        end
        if (n >= 300) begin
            checks++; errors++;
            $display("FAIL done_timeout: done count %0d, required %0d", base, base + 1);
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if ({b0.mem_we, b0.in_ready, busy0, done0} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: we/ready/busy/done=%b, required 0000",
                     {b0.mem_we, b0.in_ready, busy0, done0});
        end
        checks++;
        if (b0.mem_addr !== 32'h0 || b0.mem_wdata !== 8'h00 || sat0 !== 16'h0) begin
            errors++;
            $display("FAIL reset_values: addr=%h data=%h sat=%0d, required 0 0 0",
                     b0.mem_addr, b0.mem_wdata, sat0);
        end
        reset_n = 1'b1;
        @(posedge Clk); #1;
    endtask

    task automatic test_1x1();
        logic [31:0] ea[4];
        logic [7:0]  ed[4];
        int w, d, dw;
        ea = '{32'h100, 32'h101, 32'h102, 32'h103};
        ed = '{8'h0A, 8'h14, 8'hFF, 8'h00};
        w = wa0.size(); d = doneCnt0; dw = doneWe0;
        start_frame(0, 32'h100, 16'd1, 16'd1);
        send(0, 32'd10); send(0, 32'd20); send(0, 32'd300);
        b0.in_valid = 1'b0;
        wait_done(0, d);
        repeat (3) @(posedge Clk); #1;
        checks++;
        if (wa0.size() - w != 4) begin
            errors++;
            $display("FAIL 1x1_count: writes=%0d, required 4", wa0.size() - w);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (w + k >= wa0.size() || wa0[w+k] !== ea[k] || wd0[w+k] !== ed[k]) begin
                errors++;
                $display("FAIL 1x1_write%0d: got missing or other, required %h=%h", k, ea[k], ed[k]);
            end
        end
        checks++;
        if (sat0 !== 16'd1) begin
            errors++;
            $display("FAIL 1x1_sat: sat_count=%0d, required 1", sat0);
        end
        checks++;
        if (doneCnt0 - d != 1 || doneWe0 - dw != 1) begin
            errors++;
            $display("FAIL 1x1_done: pulses=%0d with_final_write=%0d, required 1 1",
                     doneCnt0 - d, doneWe0 - dw);
        end
    endtask

    task automatic test_no_pad();
        int w, d, p;
        w = wa0.size(); d = doneCnt0; p = padCyc0;
        start_frame(0, 32'h0, 16'd4, 16'd2);
        for (int k = 0; k < 24; k++) send(0, 32'(k * 10));
        b0.in_valid = 1'b0;
        wait_done(0, d);
        checks++;
        if (wa0.size() - w != 24) begin
            errors++;
            $display("FAIL nopad_count: writes=%0d, required 24", wa0.size() - w);
        end
        for (int k = 0; k < 24; k++) begin
            checks++;
            if (w + k >= wa0.size() || wa0[w+k] !== 32'(k) || wd0[w+k] !== 8'(k * 10)) begin
                errors++;
                $display("FAIL nopad_write%0d: got other or missing, required %0d=%0d", k, k, k * 10);
            end
        end
        checks++;
        if (padCyc0 - p != 0) begin
            errors++;
            $display("FAIL nopad_padcycles: pad cycles=%0d, required 0", padCyc0 - p);
        end
    endtask

    task automatic test_pad();
        int w, d, p;
        logic [7:0] exp;
        w = wa0.size(); d = doneCnt0; p = padCyc0;
        start_frame(0, 32'h40, 16'd2, 16'd2);
        for (int k = 0; k < 12; k++) send(0, 32'(k + 1));
        b0.in_valid = 1'b0;
        wait_done(0, d);
        checks++;
        if (wa0.size() - w != 16) begin
            errors++;
            $display("FAIL pad_count: writes=%0d, required 16", wa0.size() - w);
        end
        for (int k = 0; k < 16; k++) begin
            exp = (k % 8 < 6) ? 8'((k / 8) * 6 + (k % 8) + 1) : 8'h00;
            checks++;
            if (w + k >= wa0.size() || wa0[w+k] !== 32'(32'h40 + k) || wd0[w+k] !== exp) begin
                errors++;
                $display("FAIL pad_write%0d: got other or missing, required %h=%h", k, 32'h40 + k, exp);
            end
        end
        checks++;
        if (padCyc0 - p != 4) begin
            errors++;
            $display("FAIL pad_ready_low: busy&!in_ready cycles=%0d, required 4", padCyc0 - p);
        end
    endtask

    // Gaps between results, plus a start pulse mid-frame that must be ignored.
    task automatic test_backpressure();
        int w, d;
        logic [7:0] exp;
        w = wa0.size(); d = doneCnt0;
        start_frame(0, 32'h200, 16'd2, 16'd1);
        for (int k = 0; k < 6; k++) begin
            send(0, 32'(8'h30 + k));
            b0.in_valid = 1'b0;
            b0.in_data  = 32'hDEAD;
            if (k == 1) begin
                start_frame(0, 32'h999, 16'd7, 16'd7);
                @(posedge Clk); #1;
            end else begin
                repeat (2) @(posedge Clk);
                #1;
            end
        end
        wait_done(0, d);
        checks++;
        if (wa0.size() - w != 8) begin
            errors++;
            $display("FAIL bp_count: writes=%0d, required 8", wa0.size() - w);
        end
        for (int k = 0; k < 8; k++) begin
            exp = (k < 6) ? 8'(8'h30 + k) : 8'h00;
            checks++;
            if (w + k >= wa0.size() || wa0[w+k] !== 32'(32'h200 + k) || wd0[w+k] !== exp) begin
                errors++;
                $display("FAIL bp_write%0d: got other or missing, required %h=%h", k, 32'h200 + k, exp);
            end
        end
    endtask

    task automatic test_zero_cols();
        int w, d;
        w = wa0.size(); d = doneCnt0;
        start_frame(0, 32'h600, 16'd0, 16'd3);
        checks++;
        if (done0 !== 1'b1 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL zero_done_now: done=%b busy=%b, required 1 0", done0, busy0);
        end
        repeat (5) @(posedge Clk); #1;
        checks++;
        if (done0 !== 1'b0 || doneCnt0 - d != 1 || wa0.size() != w) begin
            errors++;
            $display("FAIL zero_after: done=%b pulses=%0d writes=%0d, required 0 1 0",
                     done0, doneCnt0 - d, wa0.size() - w);
        end
    endtask

    task automatic test_shift();
        int w, d;
        logic [7:0] ed[4];
        ed = '{8'h00, 8'hFF, 8'h7F, 8'h00};
        w = wa4.size(); d = doneCnt4;
        start_frame(1, 32'h0, 16'd1, 16'd1);
        send(1, -32'sd5); send(1, 32'd4095); send(1, 32'h7F0);
        b4.in_valid = 1'b0;
        wait_done(1, d);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (w + k >= wa4.size() || wa4[w+k] !== 32'(k) || wd4[w+k] !== ed[k]) begin
                errors++;
                $display("FAIL shift_write%0d: got other or missing, required %0d=%h", k, k, ed[k]);
            end
        end
        d = doneCnt4;
        start_frame(1, 32'h0, 16'd1, 16'd1);
        send(1, -32'sd5); send(1, 32'd4096); send(1, 32'h7F0);
        b4.in_valid = 1'b0;
        wait_done(1, d);
        checks++;
        if (sat4 !== 16'd2 || wd4[wd4.size()-3] !== 8'hFF) begin
            errors++;
            $display("FAIL shift_sat: sat_count=%0d byte=%h, required 2 ff", sat4, wd4[wd4.size()-3]);
        end
    endtask

    task automatic test_reset_midframe();
        int w, d;
        start_frame(0, 32'h300, 16'd4, 16'd2);
        send(0, 32'd1); send(0, 32'd2); send(0, 32'd3);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({b0.mem_we, b0.in_ready, busy0, done0} !== 4'b0000 || sat0 !== 16'h0) begin
            errors++;
            $display("FAIL midreset_out: we/ready/busy/done=%b sat=%0d, required 0000 0",
                     {b0.mem_we, b0.in_ready, busy0, done0}, sat0);
        end
        b0.in_valid = 1'b0;
        repeat (2) @(posedge Clk);
        #1 reset_n = 1'b1;
        repeat (3) @(posedge Clk); #1;
        w = wa0.size(); d = doneCnt0;
        checks++;
        if (busy0 !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle: busy=%b, required 0", busy0);
        end
        start_frame(0, 32'h500, 16'd1, 16'd1);
        send(0, 32'd1); send(0, 32'd2); send(0, 32'd3);
        b0.in_valid = 1'b0;
        wait_done(0, d);
        checks++;
        if (wa0.size() - w != 4 || wa0[w] !== 32'h500 || wd0[w] !== 8'h01) begin
            errors++;
            $display("FAIL midreset_restart: writes=%0d first=%h, required 4 500=01",
                     wa0.size() - w, (wa0.size() > w) ? wa0[w] : 32'hx);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    initial begin
        start0 = 1'b0; start4 = 1'b0;
        base_addr = '0; img_cols = '0; img_rows = '0;
        b0.in_valid = 1'b0; b0.in_data = '0;
        b4.in_valid = 1'b0; b4.in_data = '0;
        test_reset();
        test_1x1();
        test_no_pad();
        test_pad();
        test_backpressure();
        test_zero_cols();
        test_shift();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
